// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the hazard scoreboard: operand-select encodings and the
// shadow pipeline stage record.
package hazard_scoreboard_pkg;

  localparam int MAX_REG_W = 8;

  localparam logic [1:0] FWD_EX  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_RF  = 2'b11;

  typedef logic [1:0] fwd_sel_t;

  typedef struct packed {
    logic                 valid;
    logic                 rf_en;
    logic                 load;
    logic [MAX_REG_W-1:0] dest;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE = '0;

  function automatic logic rec_match(stage_rec_t rec, logic [MAX_REG_W-1:0] src);
    return rec.valid & rec.rf_en & (rec.dest == src);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage request signals and hazard/forwarding responses of the scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_sa, id_sb, id_sd;
  logic             id_use_a, id_use_b, id_use_d;
  logic             id_valid, id_rf_en, id_load;
  logic [REG_W-1:0] id_dest;
  logic             flush;

  logic [1:0]       fwd_a, fwd_b, fwd_d;
  logic             IF_ID_load, PC_RF_ld, nop_sel, mem_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_sa, id_sb, id_sd, id_use_a, id_use_b, id_use_d,
           id_valid, id_rf_en, id_load, id_dest, flush,
    input  fwd_a, fwd_b, fwd_d, IF_ID_load, PC_RF_ld, nop_sel, mem_busy, stall_cnt
  );

  modport slave (
    input  id_sa, id_sb, id_sd, id_use_a, id_use_b, id_use_d,
           id_valid, id_rf_en, id_load, id_dest, flush,
    output fwd_a, fwd_b, fwd_d, IF_ID_load, PC_RF_ld, nop_sel, mem_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard_fwd_select.sv
// Operand forwarding select for one source specifier; also flags a load in EX
// that this operand depends on. Purely combinational.
module fwd_select
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  input  stage_rec_t       ex,
  input  stage_rec_t       mem,
  input  stage_rec_t       wb,
  input  logic             mem_busy,
  output fwd_sel_t         sel,
  output logic             load_hit
);

  logic [MAX_REG_W-1:0] src_x;
  logic                 live, hit_ex, hit_mem, hit_wb;

  always_comb begin
    src_x   = MAX_REG_W'(src);
    // The all-ones specifier is the PC: it always reads from the register file.
    live    = use_src & ~(&src);
    hit_ex  = live & rec_match(ex, src_x);
    hit_mem = live & rec_match(mem, src_x);
    hit_wb  = live & rec_match(wb, src_x);

    sel = FWD_RF;
    if (hit_ex && !ex.load)
      sel = FWD_EX;
    else if (hit_mem && !mem_busy)
      sel = FWD_MEM;
    else if (hit_wb)
      sel = FWD_WB;

    load_hit = hit_ex & ex.load;
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks EX/MEM/WB destinations, selects forwarding
// paths, inserts load-use bubbles and freezes the front end during multi-cycle loads.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int REG_W   = 4,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input logic          clk,
  input logic          Reset,
  hazard_scoreboard_if.slave bus
);

  localparam int              CD_W    = 3;
  localparam logic [CD_W-1:0] LOAD_CD = CD_W'(MEM_LAT - 1);

  stage_rec_t       ex_q, mem_q, wb_q, id_rec;
  logic [CD_W-1:0]  cd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             squash_q;
  logic             busy, id_live, load_use, stall, nop;
  logic             hit_a, hit_b, hit_d;

  fwd_select #(.REG_W(REG_W)) u_fwd_a (
    .src(bus.id_sa), .use_src(bus.id_use_a), .ex(ex_q), .mem(mem_q), .wb(wb_q),
    .mem_busy(busy), .sel(bus.fwd_a), .load_hit(hit_a)
  );
  fwd_select #(.REG_W(REG_W)) u_fwd_b (
    .src(bus.id_sb), .use_src(bus.id_use_b), .ex(ex_q), .mem(mem_q), .wb(wb_q),
    .mem_busy(busy), .sel(bus.fwd_b), .load_hit(hit_b)
  );
  fwd_select #(.REG_W(REG_W)) u_fwd_d (
    .src(bus.id_sd), .use_src(bus.id_use_d), .ex(ex_q), .mem(mem_q), .wb(wb_q),
    .mem_busy(busy), .sel(bus.fwd_d), .load_hit(hit_d)
  );

  // An instruction fetched under a taken branch reaches ID squashed.
  assign busy     = (cd_q != '0);
  assign id_live  = bus.id_valid & ~squash_q;
  assign load_use = id_live & (hit_a | hit_b | hit_d);
  assign stall    = busy | load_use;
  assign nop      = load_use & ~busy;

  assign bus.IF_ID_load = ~stall;
  assign bus.PC_RF_ld   = ~stall;
  assign bus.nop_sel    = nop;
  assign bus.mem_busy   = busy;
  assign bus.stall_cnt  = cnt_q;

  always_comb begin
    id_rec = BUBBLE;
    if (id_live && !nop) begin
      id_rec.valid = 1'b1;
      id_rec.rf_en = bus.id_rf_en;
      id_rec.load  = bus.id_load;
      id_rec.dest  = MAX_REG_W'(bus.id_dest);
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      ex_q     <= BUBBLE;
      mem_q    <= BUBBLE;
      wb_q     <= BUBBLE;
      cd_q     <= '0;
      cnt_q    <= '0;
      squash_q <= 1'b0;
    end else begin
      if (!busy) begin
        ex_q  <= id_rec;
        mem_q <= ex_q;
        wb_q  <= mem_q;
        cd_q  <= (ex_q.valid && ex_q.load) ? LOAD_CD : '0;
      end else begin
        wb_q <= BUBBLE;
        cd_q <= cd_q - CD_W'(1);
      end
      // A flush arriving while stalled is dropped; the branch source reissues it.
      if (!stall)
        squash_q <= bus.flush;
      if (stall && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: vector table through an expectation queue, plus
// multi-cycle load, mid-load reset and counter saturation sequences.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] s_sa = '0, s_sb = '0, s_sd = '0, s_dest = '0;
  logic       s_ua = 0, s_ub = 0, s_ud = 0, s_v = 0, s_rf = 0, s_ld = 0, s_fl = 0;

  hazard_scoreboard_if #(.REG_W(4), .CNT_W(16)) if1 ();
  hazard_scoreboard_if #(.REG_W(4), .CNT_W(16)) if3 ();
  hazard_scoreboard_if #(.REG_W(4), .CNT_W(2))  ifc ();

  assign if1.id_sa = s_sa, if1.id_sb = s_sb, if1.id_sd = s_sd, if1.id_use_a = s_ua,
         if1.id_use_b = s_ub, if1.id_use_d = s_ud, if1.id_valid = s_v, if1.id_rf_en = s_rf,
         if1.id_load = s_ld, if1.id_dest = s_dest, if1.flush = s_fl;
  assign if3.id_sa = s_sa, if3.id_sb = s_sb, if3.id_sd = s_sd, if3.id_use_a = s_ua,
         if3.id_use_b = s_ub, if3.id_use_d = s_ud, if3.id_valid = s_v, if3.id_rf_en = s_rf,
         if3.id_load = s_ld, if3.id_dest = s_dest, if3.flush = s_fl;
  assign ifc.id_sa = s_sa, ifc.id_sb = s_sb, ifc.id_sd = s_sd, ifc.id_use_a = s_ua,
         ifc.id_use_b = s_ub, ifc.id_use_d = s_ud, ifc.id_valid = s_v, ifc.id_rf_en = s_rf,
         ifc.id_load = s_ld, ifc.id_dest = s_dest, ifc.flush = s_fl;

  hazard_scoreboard #(.REG_W(4), .MEM_LAT(1), .CNT_W(16)) u_dut  (.clk(clk), .Reset(rst), .bus(if1));
  hazard_scoreboard #(.REG_W(4), .MEM_LAT(3), .CNT_W(16)) u_dut3 (.clk(clk), .Reset(rst), .bus(if3));
  hazard_scoreboard #(.REG_W(4), .MEM_LAT(1), .CNT_W(2))  u_dutc (.clk(clk), .Reset(rst), .bus(ifc));

  typedef struct {
    logic [3:0] sa, sb, sd;
    logic       ua, ub, ud, v, rf, ld;
    logic [3:0] dest;
    logic       fl;
    logic [1:0] fa, fb, fd;
    logic       ifl, nop;
    int         sc;
  } vec_t;

  vec_t vecs[24];
  vec_t expq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input logic [3:0] sa, sb, sd, input logic ua, ub, ud, v, rf, ld,
                        input logic [3:0] dest, input logic fl);
    s_sa = sa; s_sb = sb; s_sd = sd; s_ua = ua; s_ub = ub; s_ud = ud;
    s_v = v; s_rf = rf; s_ld = ld; s_dest = dest; s_fl = fl;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int   cm;
    vec_t e;

    //          sa  sb sd  ua ub ud  v rf ld dest fl   fa     fb     fd    ifl nop sc
    vecs[0]  = '{3,  4, 0,  1, 1, 0, 1, 1, 0, 1,  0, 2'b11, 2'b11, 2'b11, 1, 0, 0};
    vecs[1]  = '{1,  2, 0,  1, 1, 0, 1, 1, 0, 6,  0, 2'b00, 2'b11, 2'b11, 1, 0, 0};
    vecs[2]  = '{2,  1, 0,  1, 1, 0, 1, 1, 0, 7,  0, 2'b11, 2'b10, 2'b11, 1, 0, 0};
    vecs[3]  = '{6,  7, 1,  1, 1, 1, 1, 0, 0, 0,  0, 2'b10, 2'b00, 2'b01, 1, 0, 0};
    vecs[4]  = '{15, 0, 0,  1, 0, 0, 1, 1, 1, 2,  0, 2'b11, 2'b11, 2'b11, 1, 0, 0};
    vecs[5]  = '{9,  2, 0,  1, 1, 0, 1, 1, 0, 8,  0, 2'b11, 2'b11, 2'b11, 0, 1, 0};
    vecs[6]  = '{9,  2, 0,  1, 1, 0, 1, 1, 0, 8,  0, 2'b11, 2'b10, 2'b11, 1, 0, 1};
    vecs[7]  = '{0,  0, 0,  1, 1, 0, 1, 1, 0, 5,  0, 2'b11, 2'b11, 2'b11, 1, 0, 1};
    vecs[8]  = '{8,  5, 0,  1, 1, 0, 1, 1, 0, 10, 0, 2'b10, 2'b00, 2'b11, 1, 0, 1};
    vecs[9]  = '{5,  8, 0,  1, 1, 0, 1, 1, 0, 5,  0, 2'b10, 2'b01, 2'b11, 1, 0, 1};
    vecs[10] = '{15, 10, 5, 1, 1, 1, 1, 0, 0, 0,  0, 2'b11, 2'b10, 2'b00, 1, 0, 1};
    vecs[11] = '{5,  10, 5, 0, 1, 1, 1, 1, 0, 15, 0, 2'b11, 2'b01, 2'b10, 1, 0, 1};
    vecs[12] = '{15, 5, 0,  1, 1, 0, 0, 1, 0, 5,  0, 2'b11, 2'b01, 2'b11, 1, 0, 1};
    vecs[13] = '{5,  15, 0, 1, 1, 0, 1, 0, 0, 0,  0, 2'b11, 2'b11, 2'b11, 1, 0, 1};
    vecs[14] = '{0,  0, 0,  0, 0, 0, 1, 1, 1, 4,  0, 2'b11, 2'b11, 2'b11, 1, 0, 1};
    vecs[15] = '{4,  0, 0,  1, 0, 0, 0, 1, 0, 0,  0, 2'b11, 2'b11, 2'b11, 1, 0, 1};
    vecs[16] = '{4,  0, 0,  1, 0, 0, 1, 1, 0, 9,  1, 2'b10, 2'b11, 2'b11, 1, 0, 1};
    vecs[17] = '{9,  0, 0,  1, 0, 0, 1, 1, 0, 11, 0, 2'b00, 2'b11, 2'b11, 1, 0, 1};
    vecs[18] = '{11, 9, 0,  1, 1, 0, 1, 0, 0, 0,  0, 2'b11, 2'b10, 2'b11, 1, 0, 1};
    vecs[19] = '{0,  0, 0,  0, 0, 0, 1, 1, 1, 12, 0, 2'b11, 2'b11, 2'b11, 1, 0, 1};
    vecs[20] = '{12, 0, 0,  1, 0, 0, 1, 1, 0, 13, 1, 2'b11, 2'b11, 2'b11, 0, 1, 1};
    vecs[21] = '{12, 0, 0,  1, 0, 0, 1, 1, 0, 13, 1, 2'b10, 2'b11, 2'b11, 1, 0, 2};
    vecs[22] = '{13, 0, 0,  1, 0, 0, 1, 1, 0, 14, 0, 2'b00, 2'b11, 2'b11, 1, 0, 2};
    vecs[23] = '{14, 13, 0, 1, 1, 0, 0, 1, 0, 0,  0, 2'b11, 2'b10, 2'b11, 1, 0, 2};

    // Reset state on all three instances, with every source live.
    do_reset();
    set_in(1, 2, 3, 1, 1, 1, 0, 0, 0, 0, 0);
    #2;
    chk("rst fwd_a",  if1.fwd_a, 3);       chk("rst fwd_b", if1.fwd_b, 3);
    chk("rst fwd_d",  if1.fwd_d, 3);       chk("rst IF_ID_load", if1.IF_ID_load, 1);
    chk("rst PC_RF_ld", if1.PC_RF_ld, 1);  chk("rst nop_sel", if1.nop_sel, 0);
    chk("rst mem_busy", if1.mem_busy, 0);  chk("rst stall_cnt", if1.stall_cnt, 0);
    chk("rst3 mem_busy", if3.mem_busy, 0); chk("rst3 fwd_b", if3.fwd_b, 3);
    chk("rstc stall_cnt", ifc.stall_cnt, 0);

    // Vector table against the MEM_LAT=1 instance.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      set_in(vecs[i].sa, vecs[i].sb, vecs[i].sd, vecs[i].ua, vecs[i].ub, vecs[i].ud,
             vecs[i].v, vecs[i].rf, vecs[i].ld, vecs[i].dest, vecs[i].fl);
      expq.push_back(vecs[i]);
      #2;
      e = expq.pop_front();
      chk($sformatf("row%0d fwd_a", i), if1.fwd_a, e.fa);
      chk($sformatf("row%0d fwd_b", i), if1.fwd_b, e.fb);
      chk($sformatf("row%0d fwd_d", i), if1.fwd_d, e.fd);
      chk($sformatf("row%0d IF_ID_load", i), if1.IF_ID_load, e.ifl);
      chk($sformatf("row%0d PC_RF_ld", i), if1.PC_RF_ld, e.ifl);
      chk($sformatf("row%0d nop_sel", i), if1.nop_sel, e.nop);
      chk($sformatf("row%0d mem_busy", i), if1.mem_busy, 0);
      chk($sformatf("row%0d stall_cnt", i), if1.stall_cnt, e.sc);
    end

    // MEM_LAT=3: load in MEM freezes the front end for two cycles without a bubble.
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 0);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
    @(negedge clk);
    set_in(3, 1, 0, 1, 1, 0, 1, 1, 0, 6, 0);
    #2;
    chk("lat3 c1 mem_busy", if3.mem_busy, 1);   chk("lat3 c1 IF_ID_load", if3.IF_ID_load, 0);
    chk("lat3 c1 PC_RF_ld", if3.PC_RF_ld, 0);   chk("lat3 c1 nop_sel", if3.nop_sel, 0);
    chk("lat3 c1 fwd_a", if3.fwd_a, 3);         chk("lat3 c1 fwd_b", if3.fwd_b, 0);
    @(negedge clk); #2;
    chk("lat3 c2 mem_busy", if3.mem_busy, 1);   chk("lat3 c2 stall_cnt", if3.stall_cnt, 1);
    chk("lat3 c2 nop_sel", if3.nop_sel, 0);
    @(negedge clk); #2;
    chk("lat3 c3 mem_busy", if3.mem_busy, 0);   chk("lat3 c3 IF_ID_load", if3.IF_ID_load, 1);
    chk("lat3 c3 stall_cnt", if3.stall_cnt, 2); chk("lat3 c3 fwd_a", if3.fwd_a, 2);
    chk("lat3 c3 fwd_b", if3.fwd_b, 0);
    @(negedge clk); #2;
    chk("lat3 c4 fwd_a", if3.fwd_a, 1);         chk("lat3 c4 fwd_b", if3.fwd_b, 2);
    chk("lat3 c4 stall_cnt", if3.stall_cnt, 2);

    // Reset while a multi-cycle load is in flight, with flush and load-use pending.
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 1, 3, 0);
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #2;
    chk("midrst pre mem_busy", if3.mem_busy, 1);
    @(negedge clk); #2;
    chk("midrst pre stall_cnt", if3.stall_cnt, 1);
    rst = 1'b1;
    set_in(3, 3, 3, 1, 1, 1, 1, 1, 1, 3, 1);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("midrst mem_busy", if3.mem_busy, 0);     chk("midrst stall_cnt", if3.stall_cnt, 0);
    chk("midrst fwd_a", if3.fwd_a, 3);           chk("midrst fwd_b", if3.fwd_b, 3);
    chk("midrst fwd_d", if3.fwd_d, 3);           chk("midrst IF_ID_load", if3.IF_ID_load, 1);
    chk("midrst nop_sel", if3.nop_sel, 0);

    // CNT_W=2: back-to-back dependent loads stall every other cycle; counter pins at 3.
    do_reset();
    set_in(2, 0, 0, 1, 0, 0, 1, 1, 1, 2, 0);
    cm = 0;
    for (int i = 0; i < 10; i++) begin
      #2;
      chk($sformatf("sat c%0d IF_ID_load", i), ifc.IF_ID_load, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("sat c%0d stall_cnt", i), ifc.stall_cnt, cm);
      if (i % 2 == 1 && cm < 3) cm++;
      @(negedge clk);
    end
    #2;
    chk("sat final stall_cnt", ifc.stall_cnt, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
